// File: rtl/cpu_sram_axi_bridge.sv
// Bridge from the CPU's two SRAM-like ports (inst fetch, data access) to one AXI3 master.
// One outstanding single-beat read and one outstanding single-beat write; data reads beat inst reads.
module cpu_sram_axi_bridge #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction port
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AXI read address / data
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address / data / response
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_e;

  r_state_e    r_rstate;
  w_state_e    r_wstate;
  logic [3:0]  r_arid;
  logic [31:0] r_araddr;
  logic [1:0]  r_arsize;
  logic        r_arvalid, r_rready;
  logic [31:0] r_inst_rdata, r_data_rdata;
  logic        r_inst_data_ok, r_data_data_ok;
  logic [31:0] r_awaddr, r_wdata;
  logic [1:0]  r_awsize;
  logic [3:0]  r_wstrb;
  logic        r_awvalid, r_wvalid, r_bready, r_aw_done, r_w_done;

  logic w_r_idle, w_w_idle, w_data_rd_busy;
  logic w_data_rd_acc, w_data_wr_acc, w_inst_acc;
  logic w_aw_fin, w_w_fin, w_rd_data_done, w_wr_done;

  // NOTE: acceptance is plain continuous logic off registered state, so no latch can form.
  assign w_r_idle       = (r_rstate == R_IDLE);
  assign w_w_idle       = (r_wstate == W_IDLE);
  assign w_data_rd_busy = !w_r_idle && (r_arid == ID_DATA);

  // Stores must not finish alongside a data-owned read; loads wait out any store (RAW safety).
  assign data_addr_ok  = data_wr ? (w_w_idle && !w_data_rd_busy) : (w_r_idle && w_w_idle);
  assign w_data_rd_acc = data_req && !data_wr && data_addr_ok;
  assign w_data_wr_acc = data_req &&  data_wr && data_addr_ok;
  assign inst_addr_ok  = w_r_idle && !w_data_rd_acc;
  assign w_inst_acc    = inst_req && inst_addr_ok;

  assign w_aw_fin       = r_aw_done || (r_awvalid && awready);
  assign w_w_fin        = r_w_done  || (r_wvalid  && wready);
  assign w_rd_data_done = (r_rstate == R_R) && rvalid && (rid != ID_INST);
  assign w_wr_done      = (r_wstate == W_B) && bvalid;

  // NOTE: every state register below uses <= so all flops update together at the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate       <= R_IDLE;
      r_arid         <= '0;
      r_araddr       <= '0;
      r_arsize       <= '0;
      r_arvalid      <= 1'b0;
      r_rready       <= 1'b0;
      r_inst_rdata   <= '0;
      r_data_rdata   <= '0;
      r_inst_data_ok <= 1'b0;
    end else begin
      r_inst_data_ok <= 1'b0;
      case (r_rstate)
        R_IDLE: begin
          if (w_data_rd_acc) begin
            r_arid    <= ID_DATA;
            r_araddr  <= data_addr;
            r_arsize  <= data_size;
            r_arvalid <= 1'b1;
            r_rstate  <= R_AR;
          end else if (w_inst_acc) begin
            r_arid    <= ID_INST;
            r_araddr  <= inst_addr;
            r_arsize  <= inst_size;
            r_arvalid <= 1'b1;
            r_rstate  <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_rstate  <= R_R;
          end
        end
        R_R: begin
          if (rvalid) begin
            r_rready <= 1'b0;
            r_rstate <= R_IDLE;
            if (rid == ID_INST) begin
              r_inst_rdata   <= rdata;
              r_inst_data_ok <= 1'b1;
            end else begin
              r_data_rdata <= rdata;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wstate  <= W_IDLE;
      r_awaddr  <= '0;
      r_awsize  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_data_wr_acc) begin
            r_awaddr  <= data_addr;
            r_awsize  <= data_size;
            r_wdata   <= data_wdata;
            r_wstrb   <= data_wstrb;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_wstate  <= W_REQ;
          end
        end
        W_REQ: begin
          if (r_awvalid && awready) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && wready) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_wstate <= W_B;
          end
        end
        W_B: begin
          if (bvalid) begin
            r_bready <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Data reads and writes never complete in the same cycle, so one pulse register serves both.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_data_data_ok <= 1'b0;
    else         r_data_data_ok <= w_rd_data_done || w_wr_done;
  end

  assign inst_data_ok = r_inst_data_ok;
  assign inst_rdata   = r_inst_rdata;
  assign data_data_ok = r_data_data_ok;
  assign data_rdata   = r_data_rdata;

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arsize  = {1'b0, r_arsize};
  assign arvalid = r_arvalid;
  assign rready  = r_rready;
  assign arlen   = 4'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = ID_DATA;
  assign awaddr  = r_awaddr;
  assign awsize  = {1'b0, r_awsize};
  assign awvalid = r_awvalid;
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = ID_DATA;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = 1'b1;
  assign wvalid  = r_wvalid;
  assign bready  = r_bready;

endmodule

// File: tb/tb_cpu_sram_axi_bridge.sv
// Self-checking bench for cpu_sram_axi_bridge: AXI slave model with tunable stalls plus
// scoreboards for AR/AW requests and for inst/data completions.
module tb_cpu_sram_axi_bridge;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        inst_req = 0; logic [1:0] inst_size = 0; logic [31:0] inst_addr = 0;
  logic        inst_addr_ok, inst_data_ok; logic [31:0] inst_rdata;
  logic        data_req = 0, data_wr = 0; logic [1:0] data_size = 0; logic [3:0] data_wstrb = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic        data_addr_ok, data_data_ok; logic [31:0] data_rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic [3:0]  wstrb;
  logic        arready = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
  logic [3:0]  rid = 0;
  logic [31:0] rdata = 0;

  cpu_sram_axi_bridge #(.ID_INST(ID_INST), .ID_DATA(ID_DATA)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { logic is_store; logic [31:0] rdata; } dexp_t;
  typedef struct { logic [3:0] id; logic [31:0] addr; logic [2:0] size; } ar_t;
  typedef struct { logic [31:0] addr; logic [2:0] size; logic [3:0] strb; logic [31:0] data; } aw_t;

  logic [31:0] inst_q[$];
  dexp_t       data_q[$];
  ar_t         ar_q[$];
  aw_t         aw_q[$];
  logic [31:0] slave_mem[logic [31:0]];
  logic [31:0] exp_mem[logic [31:0]];

  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  int last_r_cyc = -10, last_b_cyc = -10, last_ar_cyc = -10, last_dok_cyc = -10;

  function automatic logic [31:0] dflt(input logic [31:0] k);
    return k ^ 32'h5A5A_3C3C;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return exp_mem.exists(k) ? exp_mem[k] : dflt(k);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return slave_mem.exists(k) ? slave_mem[k] : dflt(k);
  endfunction

  // AXI read slave: stall AR for ar_delay cycles, then answer r_delay cycles later.
  initial begin
    forever begin
      @(negedge clk);
      while (resetn && arvalid) begin
        ar_t cap;
        bit  ab;
        ab = 0;
        cap.id = arid; cap.addr = araddr; cap.size = arsize;
        last_ar_cyc = cyc;
        if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
        else begin
          ar_t e;
          e = ar_q.pop_front();
          check("arid", cap.id, e.id);
          check("araddr", cap.addr, e.addr);
          check("arsize", cap.size, e.size);
        end
        for (int i = 0; i < ar_delay; i++) begin
          @(negedge clk);
          if (!resetn) begin ab = 1; break; end
          check("ar_hold_valid", arvalid, 1);
          check("ar_hold_addr", araddr, cap.addr);
          check("ar_hold_size", arsize, cap.size);
        end
        if (!ab) begin
          arready = 1;
          @(negedge clk);
          arready = 0;
          if (!resetn) ab = 1;
          else begin
            check("ar_drop", arvalid, 0);
            check("rready_on", rready, 1);
          end
        end
        for (int i = 0; i < r_delay && !ab; i++) begin
          @(negedge clk);
          if (!resetn) ab = 1;
        end
        if (!ab) begin
          rvalid = 1; rid = cap.id; rdata = slv_rd(cap.addr);
          last_r_cyc = cyc;
          @(negedge clk);
          rvalid = 0;
          if (resetn) check("rready_off", rready, 0);
        end
        if (ab) break;
      end
    end
  end

  // AXI write slave: independent AW/W stalls, then B after b_delay cycles.
  initial begin
    forever begin
      @(negedge clk);
      while (resetn && awvalid) begin
        aw_t cap;
        int  ac, wc;
        bit  ad, wd;
        cap.addr = awaddr; cap.size = awsize; cap.strb = wstrb; cap.data = wdata;
        check("wvalid_with_aw", wvalid, 1);
        check("wlast", wlast, 1);
        if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
        else begin
          aw_t e;
          e = aw_q.pop_front();
          check("awaddr", cap.addr, e.addr);
          check("awsize", cap.size, e.size);
          check("wstrb", cap.strb, e.strb);
          check("wdata", cap.data, e.data);
        end
        ac = aw_delay; wc = w_delay; ad = 0; wd = 0;
        while (!(ad && wd)) begin
          awready = !ad && (ac == 0);
          wready  = !wd && (wc == 0);
          @(negedge clk);
          if (awready) ad = 1; else if (!ad) ac--;
          if (wready) begin
            wd = 1;
            slave_mem[{cap.addr[31:2], 2'b00}] = merge(slv_rd(cap.addr), cap.data, cap.strb);
          end else if (!wd) wc--;
          awready = 0; wready = 0;
          check("awvalid_track", awvalid, !ad);
          check("wvalid_track", wvalid, !wd);
          check("bready_after_both", bready, ad && wd);
        end
        repeat (b_delay) @(negedge clk);
        bvalid = 1;
        last_b_cyc = cyc;
        @(negedge clk);
        bvalid = 0;
        check("bready_off", bready, 0);
      end
    end
  end

  // Completion monitor: every data_ok must match the head of its port's queue.
  always @(negedge clk) begin
    if (resetn) begin
      if (inst_data_ok) begin
        if (inst_q.size() == 0) check("inst_ok_unexpected", 1, 0);
        else begin
          check("inst_rdata", inst_rdata, inst_q.pop_front());
          check("inst_ok_latency", cyc, last_r_cyc + 1);
        end
      end
      if (data_data_ok) begin
        last_dok_cyc = cyc;
        if (data_q.size() == 0) check("data_ok_unexpected", 1, 0);
        else begin
          dexp_t d;
          d = data_q.pop_front();
          if (d.is_store) check("store_ok_latency", cyc, last_b_cyc + 1);
          else begin
            check("data_rdata", data_rdata, d.rdata);
            check("load_ok_latency", cyc, last_r_cyc + 1);
          end
        end
      end
    end
  end

  task automatic do_inst(input logic [31:0] a, output int acc_cyc);
    bit done;
    done = 0; acc_cyc = -1;
    inst_req = 1; inst_addr = a; inst_size = 2'd2;
    for (int i = 0; i < 300 && !done; i++) begin
      #1;
      if (inst_addr_ok) begin
        ar_q.push_back('{ID_INST, a, 3'd2});
        inst_q.push_back(exp_rd(a));
        acc_cyc = cyc;
        done = 1;
      end
      @(negedge clk);
    end
    inst_req = 0;
    if (!done) check("inst_accept_timeout", 0, 1);
  endtask

  task automatic do_data(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                         input logic [3:0] strb, input logic [31:0] wd, output int acc_cyc);
    bit done;
    done = 0; acc_cyc = -1;
    data_req = 1; data_wr = wr; data_addr = a; data_size = sz; data_wstrb = strb; data_wdata = wd;
    for (int i = 0; i < 300 && !done; i++) begin
      #1;
      if (data_addr_ok) begin
        if (wr) begin
          aw_q.push_back('{a, {1'b0, sz}, strb, wd});
          exp_mem[{a[31:2], 2'b00}] = merge(exp_rd(a), wd, strb);
          data_q.push_back('{1'b1, 32'h0});
        end else begin
          ar_q.push_back('{ID_DATA, a, {1'b0, sz}});
          data_q.push_back('{1'b0, exp_rd(a)});
        end
        acc_cyc = cyc;
        done = 1;
      end
      @(negedge clk);
    end
    data_req = 0;
    if (!done) check("data_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (inst_q.size() == 0 && data_q.size() == 0 && ar_q.size() == 0 && aw_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check(tag, inst_q.size() + data_q.size() + ar_q.size() + aw_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ic, dc, lc;
    logic [31:0] addrs [4];
    addrs[0] = 32'h1C00_0000; addrs[1] = 32'h1C00_0104;
    addrs[2] = 32'h1C00_0208; addrs[3] = 32'h1C00_030C;

    repeat (3) @(negedge clk);
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_bready", bready, 0);
    check("rst_oks", {inst_data_ok, data_data_ok}, 0);
    check("rst_rdata", inst_rdata | data_rdata, 0);
    check("const_ar", {arlen, arburst, arlock, arcache, arprot}, {4'd0, 2'b01, 2'b00, 4'd0, 3'd0});
    check("const_aw", {awid, wid, awlen, awburst, awlock}, {ID_DATA, ID_DATA, 4'd0, 2'b01, 2'b00});
    resetn = 1;
    @(negedge clk);

    // Inst fetch with a 3-cycle AR stall and R one cycle after the handshake.
    slave_mem[32'h1C00_0000] = 32'h0280_0C0C;
    exp_mem[32'h1C00_0000]   = 32'h0280_0C0C;
    ar_delay = 3; r_delay = 1;
    do_inst(32'h1C00_0000, ic);
    wait_idle("fetch_drain");
    check("fetch_rdata_hold", inst_rdata, 32'h0280_0C0C);

    // Simultaneous inst fetch and data load: data must win.
    ar_delay = 1; r_delay = 0;
    fork
      do_data(1'b0, 32'h1C00_0100, 2'd2, 4'h0, 32'h0, dc);
      do_inst(32'h1C00_0004, ic);
      begin
        #1;
        check("inst_loses_arb", inst_addr_ok, 0);
        check("data_wins_arb", data_addr_ok, 1);
      end
    join
    wait_idle("arb_drain");
    check("inst_after_data_ok", ic >= last_dok_cyc, 1);

    // Store with W lagging AW by two cycles, then read it back.
    aw_delay = 0; w_delay = 2; b_delay = 1;
    do_data(1'b1, 32'h1C00_0200, 2'd2, 4'b0011, 32'hDEAD_BEEF, dc);
    wait_idle("store_drain");
    do_data(1'b0, 32'h1C00_0200, 2'd2, 4'h0, 32'h0, lc);
    wait_idle("store_readback_drain");

    // Load to the address of a pending store waits for the write response.
    aw_delay = 1; w_delay = 1; b_delay = 3;
    do_data(1'b1, 32'h1C00_0300, 2'd2, 4'hF, 32'hCAFE_F00D, dc);
    do_data(1'b0, 32'h1C00_0300, 2'd2, 4'h0, 32'h0, lc);
    check("load_accept_after_b", lc > last_b_cyc, 1);
    wait_idle("raw_drain");
    check("load_ar_after_b", last_ar_cyc > last_b_cyc, 1);

    // Asynchronous reset while arvalid is held.
    ar_delay = 50; r_delay = 0;
    do_inst(32'h1C00_0400, ic);
    @(negedge clk);
    check("arvalid_before_rst", arvalid, 1);
    #2 resetn = 0;
    #1;
    check("rst_async_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    check("rst_async_oks", {inst_data_ok, data_data_ok}, 0);
    check("rst_async_rdata", inst_rdata, 0);
    ar_q.delete(); inst_q.delete(); data_q.delete(); aw_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1;
    ar_delay = 0;
    repeat (5) @(negedge clk);
    check("no_stale_ok", {inst_data_ok, data_data_ok}, 0);
    do_inst(32'h1C00_0000, ic);
    wait_idle("post_reset_drain");

    // Mixed traffic with random stalls on both ports.
    for (int n = 0; n < 16; n++) begin
      logic        wr;
      logic [31:0] a;
      ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 2);
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      a  = addrs[$urandom_range(0, 3)];
      fork
        do_inst(addrs[$urandom_range(0, 3)], ic);
        do_data(wr, a, 2'd2, 4'($urandom_range(1, 15)), $urandom, dc);
      join
    end
    wait_idle("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sram_axi_bridge.md
Name: cpu_sram_axi_bridge

Overview:
- Sits directly downstream of the CPU top in the LoongArch pipeline.
- Converts the CPU's two SRAM-like request ports (instruction fetch, data access) into a single AXI3 master port toward the SoC interconnect.
- Handles one outstanding read and one outstanding write, each single-beat and 32-bit.
- Arbitrates reads between the two ports, with data given priority over inst.

Parameters:
- ID_INST, 4'd0, ARID used for instruction reads.
- ID_DATA, 4'd1, ARID/AWID/WID used for data accesses.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
inst_req  in  1  fetch request valid (read only)
inst_size  in  2  0/1/2 = 1/2/4 bytes
inst_addr  in  32  fetch address
inst_addr_ok  out  1  request accepted this cycle
inst_data_ok  out  1  read data valid pulse
inst_rdata  out  32  fetched word
data_req  in  1  data request valid
data_wr  in  1  1 = store, 0 = load
data_size  in  2  0/1/2 = 1/2/4 bytes
data_wstrb  in  4  byte enables (stores)
data_addr  in  32  access address
data_wdata  in  32  store data
data_addr_ok  out  1  request accepted this cycle
data_data_ok  out  1  load data / store completion pulse
data_rdata  out  32  loaded word
arid  out  4  read ID
araddr  out  32  read address
arsize  out  3  {1'b0, size}
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  read response ID
rdata  in  32  read data
rvalid  in  1  R valid
rready  out  1  R ready
awaddr  out  32  write address
awsize  out  3  {1'b0, data_size}
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  32  write data
wstrb  out  4  write strobes
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  B valid
bready  out  1  B ready
arlen/arburst/arlock/arcache/arprot, awid/awlen/awburst/awlock/awcache/awprot, wid/wlast  out  various  constants: len 0, burst 2'b01, lock 0, cache 0, prot 0, awid = wid = ID_DATA, wlast 1

Behaviour:
- Reset (resetn low, asynchronous):
  - Both FSMs go to IDLE.
  - arvalid, awvalid, wvalid, rready, bready, inst_data_ok, data_data_ok all 0; inst_rdata and data_rdata 0.
  - Any in-flight transaction is abandoned; no data_ok is issued for it.
- Read FSM (R_IDLE -> R_AR -> R_R -> R_IDLE):
  - Accept in R_IDLE: latch addr, size and owner ID; arvalid rises the next cycle.
  - R_AR: hold arvalid and all AR fields stable until arready; go to R_R on arvalid&arready.
  - R_R: rready = 1. On rvalid, register rdata into the owner's rdata (rid == ID_INST -> inst, else data) and pulse that owner's data_ok for exactly one cycle, the cycle after the R handshake. Return to R_IDLE in that same handshake cycle.
- Write FSM (W_IDLE -> W_REQ -> W_B -> W_IDLE):
  - Accept in W_IDLE: latch addr, size, wstrb and wdata.
  - W_REQ: awvalid and wvalid both rise the next cycle. Each drops independently on its own handshake (tracked by aw_done and w_done). Go to W_B once both are done; both may complete in the same cycle.
  - W_B: bready = 1. On bvalid, go to W_IDLE and pulse data_data_ok one cycle later. bresp is ignored.
- Acceptance (combinational addr_ok; a request is accepted when req & addr_ok):
  - Data store: addr_ok = W_IDLE & !(read FSM busy with a data-owned read). This prevents a collision on data_data_ok.
  - Data load: addr_ok = R_IDLE & W_IDLE. Loads wait for any pending store, which prevents read-after-write hazards to the same address.
  - Inst read: addr_ok = R_IDLE & !(data_req & !data_wr & data_addr_ok). Inst loses only when a data load is accepted in the same cycle.
  - A data store and an inst read may be accepted in the same cycle.
- Completion ordering:
  - Per port, data_ok returns in request order; this follows from one outstanding read and one outstanding write.
  - inst_data_ok and data_data_ok may pulse in the same cycle.
- A new request may be accepted in the cycle an FSM returns to IDLE only from the following cycle (accept requires the registered IDLE state).
- No address alignment checking; the CPU guarantees natural alignment.

Test Plan:
- Inst fetch, addr 0x1C000000: arready held low for 3 cycles, then rvalid with rid 0 and rdata 0x02800C0C one cycle later -> araddr/arsize stable during the stall, inst_data_ok pulses once, inst_rdata = 0x02800C0C, data_data_ok stays 0.
- Same-cycle inst_req and data load at 0x1C000100 -> arid 1 issued first, inst_addr_ok = 0 that cycle; inst accepted after data_data_ok.
- Store wstrb 4'b0011, wdata 0xDEADBEEF: awready 2 cycles before wready -> awvalid drops first, wvalid drops later, bready only after both; data_data_ok pulses 1 cycle after bvalid.
- Store pending, then data load to the same address -> data_addr_ok = 0 until write FSM reaches IDLE; load AR issues only after bvalid.
- resetn pulled low while arvalid = 1 -> all valids and data_ok drop immediately (asynchronously); after resetn rises, the next inst_req is accepted cleanly and no stale data_ok appears.
